// File: rtl/ones_frame_accumulator.sv
// Accumulates per-word ones counts over a frame and holds the frame summary
// (total, max, word count, saturation and error flags) until it is consumed.
module ones_frame_accumulator #(
  parameter int N  = 16,
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_count,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_total,
  output logic [N-1:0]  out_max,
  output logic [15:0]   out_words,
  output logic          out_sat,
  output logic          out_err
);

  localparam int SW = ((TW > N) ? TW : N) + 1;
  localparam logic [N-1:0] N_VAL = N'(N);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] total_q, total_d;
  logic [N-1:0]  max_q, max_d;
  logic [15:0]   words_q, words_d;
  logic          sat_q, sat_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic [TW-1:0] out_total_q, out_total_d;
  logic [N-1:0]  out_max_q, out_max_d;
  logic [15:0]   out_words_q, out_words_d;
  logic          out_sat_q, out_sat_d;
  logic          out_err_q, out_err_d;

  logic          accept;
  logic [N-1:0]  cnt_c;
  logic [SW-1:0] sum_c;
  logic [TW-1:0] tot_nxt;
  logic [N-1:0]  max_nxt;
  logic [15:0]   words_nxt;
  logic          sat_nxt;
  logic          err_nxt;

  assign in_ready = (state_q == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  // Running values as they would be after accepting the current word.
  always_comb begin
    cnt_c   = (in_count > N_VAL) ? N_VAL : in_count;
    err_nxt = err_q | (in_count > N_VAL);
    sat_nxt = sat_q;
    sum_c   = SW'(total_q) + SW'(cnt_c);
    if (sum_c > SW'({TW{1'b1}})) begin
      tot_nxt = '1;
      sat_nxt = 1'b1;
    end else begin
      tot_nxt = sum_c[TW-1:0];
    end
    if (words_q == '1) begin
      words_nxt = '1;
      sat_nxt   = 1'b1;
    end else begin
      words_nxt = words_q + 16'd1;
    end
    max_nxt = (cnt_c > max_q) ? cnt_c : max_q;
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    max_d       = max_q;
    words_d     = words_q;
    sat_d       = sat_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_total_d = out_total_q;
    out_max_d   = out_max_q;
    out_words_d = out_words_q;
    out_sat_d   = out_sat_q;
    out_err_d   = out_err_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (in_last) begin
            out_total_d = tot_nxt;
            out_max_d   = max_nxt;
            out_words_d = words_nxt;
            out_sat_d   = sat_nxt;
            out_err_d   = err_nxt;
            out_valid_d = 1'b1;
            total_d     = '0;
            max_d       = '0;
            words_d     = '0;
            sat_d       = 1'b0;
            err_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            total_d = tot_nxt;
            max_d   = max_nxt;
            words_d = words_nxt;
            sat_d   = sat_nxt;
            err_d   = err_nxt;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      total_q     <= '0;
      max_q       <= '0;
      words_q     <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_max_q   <= '0;
      out_words_q <= '0;
      out_sat_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      max_q       <= max_d;
      words_q     <= words_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_max_q   <= out_max_d;
      out_words_q <= out_words_d;
      out_sat_q   <= out_sat_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_total = out_total_q;
  assign out_max   = out_max_q;
  assign out_words = out_words_q;
  assign out_sat   = out_sat_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Randomized bench for ones_frame_accumulator with a queue-based frame model;
// a second instance with TW = 8 covers total saturation.
module tb_ones_frame_accumulator;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [15:0] in_count = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_total;
  logic [15:0] out_max, out_words;
  logic        out_sat, out_err;

  logic        b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0;
  logic [15:0] b_in_count = '0;
  logic        b_out_valid, b_out_ready = 1'b0;
  logic [7:0]  b_out_total;
  logic [15:0] b_out_max, b_out_words;
  logic        b_out_sat, b_out_err;

  int total = 0;
  int bad = 0;

  ones_frame_accumulator #(.N(16), .TW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_total(out_total), .out_max(out_max),
    .out_words(out_words), .out_sat(out_sat), .out_err(out_err)
  );

  ones_frame_accumulator #(.N(16), .TW(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_count(b_in_count), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_total(b_out_total), .out_max(b_out_max),
    .out_words(b_out_words), .out_sat(b_out_sat), .out_err(b_out_err)
  );

  // Frame summary straight from the rules: clamp, sum, max, count, saturate.
  function automatic void model(input int q[$], input int tw, output longint tot,
                                output int mx, output int wds, output bit sat, output bit err);
    longint lim;
    longint s;
    lim = (longint'(1) << tw) - 1;
    s = 0; mx = 0; sat = 0; err = 0;
    foreach (q[i]) begin
      int c;
      c = q[i];
      if (c > N) begin c = N; err = 1; end
      s += c;
      if (c > mx) mx = c;
    end
    if (s > lim) begin s = lim; sat = 1; end
    wds = q.size();
    tot = s;
  endfunction

  task automatic send_word(input int c, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_count = c[15:0]; in_last = last;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready got=%b want=1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic run_frame(input string name, input int q[$], input int stall, input int gap_max);
    longint tot; int mx, wds; bit sat, err;
    model(q, 32, tot, mx, wds, sat, err);
    out_ready = (stall == 0);
    foreach (q[i]) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          in_valid = 1'b0; in_last = 1'($urandom_range(0, 1));
          in_count = 16'($urandom_range(0, 20));
        end
      end
      send_word(q[i], i == q.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid got=%b want=1", name, out_valid); end
    total++; if (out_total !== 32'(tot)) begin bad++; $display("FAIL %s out_total got=%0d want=%0d", name, out_total, tot); end
    total++; if (out_max !== 16'(mx)) begin bad++; $display("FAIL %s out_max got=%0d want=%0d", name, out_max, mx); end
    total++; if (out_words !== 16'(wds)) begin bad++; $display("FAIL %s out_words got=%0d want=%0d", name, out_words, wds); end
    total++; if (out_sat !== sat) begin bad++; $display("FAIL %s out_sat got=%b want=%b", name, out_sat, sat); end
    total++; if (out_err !== err) begin bad++; $display("FAIL %s out_err got=%b want=%b", name, out_err, err); end
    repeat (stall) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_total !== 32'(tot) || out_words !== 16'(wds)) begin
        bad++;
        $display("FAIL %s hold got v=%b rdy=%b tot=%0d w=%0d want v=1 rdy=0 tot=%0d w=%0d",
                 name, out_valid, in_ready, out_total, out_words, tot, wds);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s release got v=%b rdy=%b want v=0 rdy=1", name, out_valid, in_ready);
    end
    total++; if (out_total !== 32'(tot) || out_max !== 16'(mx) || out_words !== 16'(wds)) begin
      bad++; $display("FAIL %s retain got tot=%0d max=%0d w=%0d want tot=%0d max=%0d w=%0d",
                      name, out_total, out_max, out_words, tot, mx, wds);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0 || out_total !== 32'd0 || out_max !== 16'd0 || out_words !== 16'd0 ||
                 out_sat !== 1'b0 || out_err !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got v=%b tot=%0d max=%0d w=%0d sat=%b err=%b want all 0",
                      out_valid, out_total, out_max, out_words, out_sat, out_err);
    end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_in_hold();
    send_word(4, 1'b0);
    send_word(4, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_rst_pending got=%b want=1", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_rst_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      total++; if (out_valid !== 1'b0 || out_total !== 32'd0) begin
        bad++; $display("FAIL hold_rst_discard got v=%b tot=%0d want v=0 tot=0", out_valid, out_total);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    send_word(7, 1'b0);
    send_word(9, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rst", '{1, 2}, 0, 0);
  endtask

  task automatic test_sat_tw8();
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_count = 16'd16; b_in_last = (i == 19);
      @(posedge clk);
    end
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0;
    while (!b_out_valid && n < 5) begin @(negedge clk); n++; end
    total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL tw8_valid got=%b want=1", b_out_valid); end
    total++; if (b_out_total !== 8'd255 || b_out_sat !== 1'b1) begin
      bad++; $display("FAIL tw8_sat got tot=%0d sat=%b want tot=255 sat=1", b_out_total, b_out_sat);
    end
    total++; if (b_out_words !== 16'd20 || b_out_max !== 16'd16 || b_out_err !== 1'b0) begin
      bad++; $display("FAIL tw8_fields got w=%0d max=%0d err=%b want w=20 max=16 err=0", b_out_words, b_out_max, b_out_err);
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      bad++; $display("FAIL tw8_release got v=%b rdy=%b want v=0 rdy=1", b_out_valid, b_in_ready);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 15; f++) begin
      int q[$];
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 20));
      run_frame($sformatf("rand%0d", f), q, $urandom_range(0, 3), 2);
    end
  endtask

  initial begin
    test_reset();
    run_frame("basic", '{3, 16, 0, 7}, 0, 0);
    run_frame("stall5", '{2, 11, 6}, 5, 0);
    run_frame("clamp_err", '{20, 5}, 0, 0);
    test_reset_midframe();
    run_frame("b2b_a", '{5}, 0, 0);
    run_frame("b2b_b", '{9}, 0, 0);
    test_reset_in_hold();
    test_sat_tw8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
